// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed 7-segment scan controller with double-buffered image, blink, LZB and PWM brightness
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lzb_en,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic [7:0]              fnd_data
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [SW-1:0]           slot_cnt;
  logic [DW-1:0]           dig_sel;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] sh_val, ac_val;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_blink, ac_dp, ac_blink;
  logic                    sh_lzb, ac_lzb, pending;
  logic                    slot_wrap, boundary, lit, run;
  logic [SW+3:0]           thr;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              code;
  logic [7:0]              seg;

  function automatic logic [7:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:    glyph = 8'hFC;
      4'd1:    glyph = 8'h60;
      4'd2:    glyph = 8'hDA;
      4'd3:    glyph = 8'hF2;
      4'd4:    glyph = 8'h66;
      4'd5:    glyph = 8'hB6;
      4'd6:    glyph = 8'hBE;
      4'd7:    glyph = 8'hE4;
      4'd8:    glyph = 8'hFE;
      4'd9:    glyph = 8'hF6;
      4'd10:   glyph = 8'hC6;
      4'd11:   glyph = 8'h3A;
      4'd12:   glyph = 8'hFC;
      4'd13:   glyph = 8'h02;
      default: glyph = 8'h00;
    endcase
  endfunction

  assign slot_wrap  = slot_cnt == SW'(SCAN_DIV - 1);
  assign boundary   = slot_wrap && dig_sel == '0;
  assign frame_tick = boundary;
  assign load_ack   = boundary & pending;
  assign thr        = ((SW+4)'(brightness) * (SW+4)'(SCAN_DIV)) >> 4;
  assign lit        = brightness == 4'd15 || {4'b0, slot_cnt} < thr;
  assign code       = ac_val[{dig_sel, 2'b00} +: 4];

  // A run of zero codes from the leftmost digit is blanked; digit 0 always shows.
  always_comb begin
    blank = '0;
    run   = ac_lzb;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run      = run & (ac_val[4*i +: 4] == 4'd0);
      blank[i] = run;
    end
  end

  assign seg = (blink_phase & ac_blink[dig_sel]) ? 8'h00
             : ((blank[dig_sel] ? 8'h00 : glyph(code)) | {7'b0, ac_dp[dig_sel]});

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt    <= '0;
      dig_sel     <= DW'(NUM_DIGITS - 1);
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SW'(1);
      if (slot_wrap) dig_sel <= dig_sel == '0 ? DW'(NUM_DIGITS - 1) : dig_sel - DW'(1);
      if (boundary) begin
        blink_cnt <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + BW'(1);
        if (blink_cnt == BW'(BLINK_DIV - 1)) blink_phase <= ~blink_phase;
      end
    end
  end

  // Shadow takes every load; active only changes at a frame boundary so frames never tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val   <= {NUM_DIGITS{4'hF}};
      sh_dp    <= '0;
      sh_blink <= '0;
      sh_lzb   <= 1'b0;
      ac_val   <= {NUM_DIGITS{4'hF}};
      ac_dp    <= '0;
      ac_blink <= '0;
      ac_lzb   <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        sh_val   <= digit_val;
        sh_dp    <= dp_en;
        sh_blink <= blink_en;
        sh_lzb   <= lzb_en;
      end
      if (load_ack) begin
        ac_val   <= sh_val;
        ac_dp    <= sh_dp;
        ac_blink <= sh_blink;
        ac_lzb   <= sh_lzb;
      end
      pending <= load | (pending & ~boundary);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fnd_com  <= '1;
      fnd_data <= 8'h00;
    end else begin
      fnd_com  <= lit ? ~(NUM_DIGITS'(1) << dig_sel) : '1;
      fnd_data <= lit ? seg : 8'h00;
    end
  end
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed bench for fnd_scan_ctrl with 4 digits, 4-cycle slots, 2-frame blink
module tb_fnd_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digit_val = 16'hFFFF;
  logic [3:0]  dp_en = 4'b0, blink_en = 4'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic        load = 1'b0;
  logic        load_ack, frame_tick;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  int          vec = 0, err = 0;

  fnd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst(rst), .digit_val(digit_val), .dp_en(dp_en), .blink_en(blink_en),
    .lzb_en(lzb_en), .brightness(brightness), .load(load), .load_ack(load_ack),
    .frame_tick(frame_tick), .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  always #5 clk = ~clk;

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut;
    rst  = 1'b1;
    load = 1'b0;
    skip(3);
    rst = 1'b0;
  endtask

  // Entered at a frame start; samples the first slot of each digit, leftmost first.
  task automatic cap_frame(output logic [31:0] d);
    d = '0;
    for (int j = 0; j < 4; j++) begin
      skip(1);
      d[8*(3-j) +: 8] = fnd_data;
      skip(3);
    end
  endtask

  task automatic load_img(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl, input logic lz);
    digit_val = v;
    dp_en     = dp;
    blink_en  = bl;
    lzb_en    = lz;
    load      = 1'b1;
    skip(1);
    load = 1'b0;
    skip(15);
  endtask

  task automatic test_reset;
    logic [3:0] ec;
    logic       et;
    reset_dut;
    vec++; if (fnd_com !== 4'hF) begin err++; $display("FAIL reset_com got %b want 1111", fnd_com); end
    vec++; if (fnd_data !== 8'h00) begin err++; $display("FAIL reset_data got %h want 00", fnd_data); end
    vec++; if (load_ack !== 1'b0) begin err++; $display("FAIL reset_ack got %b want 0", load_ack); end
    vec++; if (frame_tick !== 1'b0) begin err++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    for (int k = 1; k <= 32; k++) begin
      skip(1);
      ec = ~(4'b0001 << (3 - ((k - 1) / 4) % 4));
      et = (k % 16) == 15;
      vec++; if (fnd_com !== ec) begin err++; $display("FAIL scan_com k=%0d got %b want %b", k, fnd_com, ec); end
      vec++; if (fnd_data !== 8'h00) begin err++; $display("FAIL scan_data k=%0d got %h want 00", k, fnd_data); end
      vec++; if (frame_tick !== et) begin err++; $display("FAIL scan_tick k=%0d got %b want %b", k, frame_tick, et); end
    end
  endtask

  task automatic test_lzb;
    logic [31:0] d;
    reset_dut;
    load_img(16'h0012, 4'b0, 4'b0, 1'b1);
    cap_frame(d);
    vec++; if (d !== 32'h000060DA) begin err++; $display("FAIL lzb_on got %h want 000060DA", d); end
    load_img(16'h0012, 4'b0, 4'b0, 1'b0);
    cap_frame(d);
    vec++; if (d !== 32'hFCFC60DA) begin err++; $display("FAIL lzb_off got %h want FCFC60DA", d); end
    load_img(16'h0000, 4'b0, 4'b0, 1'b1);
    cap_frame(d);
    vec++; if (d !== 32'h000000FC) begin err++; $display("FAIL lzb_zero got %h want 000000FC", d); end
  endtask

  task automatic test_buffering;
    logic [31:0] d;
    int          acks;
    reset_dut;
    load_img(16'h0012, 4'b0, 4'b0, 1'b0);
    skip(6);
    digit_val = 16'hABCD;
    load = 1'b1;
    skip(1);
    load = 1'b0;
    skip(2);
    vec++; if (fnd_data !== 8'h60) begin err++; $display("FAIL buf_old_d1 got %h want 60", fnd_data); end
    skip(4);
    vec++; if (fnd_data !== 8'hDA) begin err++; $display("FAIL buf_old_d0 got %h want DA", fnd_data); end
    skip(1);
    vec++; if (load_ack !== 1'b0) begin err++; $display("FAIL buf_ack_early got %b want 0", load_ack); end
    skip(1);
    vec++; if (load_ack !== 1'b1) begin err++; $display("FAIL buf_ack got %b want 1", load_ack); end
    vec++; if (frame_tick !== 1'b1) begin err++; $display("FAIL buf_tick got %b want 1", frame_tick); end
    skip(1);
    vec++; if (load_ack !== 1'b0) begin err++; $display("FAIL buf_ack_late got %b want 0", load_ack); end
    cap_frame(d);
    vec++; if (d !== 32'hC63AFC02) begin err++; $display("FAIL buf_new got %h want C63AFC02", d); end
    skip(2);
    digit_val = 16'h1234;
    load = 1'b1;
    skip(1);
    load = 1'b0;
    skip(3);
    digit_val = 16'h5678;
    load = 1'b1;
    skip(1);
    load = 1'b0;
    acks = 0;
    repeat (9) begin
      skip(1);
      acks += int'(load_ack);
    end
    vec++; if (acks != 1) begin err++; $display("FAIL b2b_acks got %0d want 1", acks); end
    cap_frame(d);
    vec++; if (d !== 32'hB6BEE4FE) begin err++; $display("FAIL b2b_last got %h want B6BEE4FE", d); end
  endtask

  task automatic test_blink;
    logic [31:0] d, e;
    reset_dut;
    load_img(16'h1238, 4'b0, 4'b0001, 1'b0);
    for (int f = 1; f <= 5; f++) begin
      cap_frame(d);
      e = (f == 2 || f == 3) ? 32'h60DAF200 : 32'h60DAF2FE;
      vec++; if (d !== e) begin err++; $display("FAIL blink f=%0d got %h want %h", f, d, e); end
    end
  endtask

  task automatic test_brightness;
    logic [3:0] ec;
    logic [7:0] ed;
    brightness = 4'd15;
    reset_dut;
    load_img(16'h8888, 4'b0, 4'b0, 1'b0);
    brightness = 4'd0;
    for (int k = 17; k <= 32; k++) begin
      skip(1);
      vec++; if (fnd_com !== 4'hF) begin err++; $display("FAIL bri0_com k=%0d got %b want 1111", k, fnd_com); end
      vec++; if (fnd_data !== 8'h00) begin err++; $display("FAIL bri0_data k=%0d got %h want 00", k, fnd_data); end
    end
    brightness = 4'd8;
    for (int k = 33; k <= 48; k++) begin
      skip(1);
      ec = ((k - 1) % 4 < 2) ? ~(4'b0001 << (3 - ((k - 1) / 4) % 4)) : 4'hF;
      ed = ((k - 1) % 4 < 2) ? 8'hFE : 8'h00;
      vec++; if (fnd_com !== ec) begin err++; $display("FAIL bri8_com k=%0d got %b want %b", k, fnd_com, ec); end
      vec++; if (fnd_data !== ed) begin err++; $display("FAIL bri8_data k=%0d got %h want %h", k, fnd_data, ed); end
    end
    brightness = 4'd15;
    skip(2);
    vec++; if (fnd_com !== 4'b0111) begin err++; $display("FAIL bri15_slot1 got %b want 0111", fnd_com); end
    brightness = 4'd4;
    skip(1);
    vec++; if (fnd_com !== 4'hF) begin err++; $display("FAIL bri4_slot2 got %b want 1111", fnd_com); end
    skip(1);
    vec++; if (fnd_com !== 4'hF) begin err++; $display("FAIL bri4_slot3 got %b want 1111", fnd_com); end
    skip(1);
    vec++; if (fnd_com !== 4'b1011) begin err++; $display("FAIL bri4_slot0 got %b want 1011", fnd_com); end
    vec++; if (fnd_data !== 8'hFE) begin err++; $display("FAIL bri4_data got %h want FE", fnd_data); end
    skip(1);
    vec++; if (fnd_com !== 4'hF) begin err++; $display("FAIL bri4_slot1 got %b want 1111", fnd_com); end
    brightness = 4'd15;
  endtask

  task automatic test_dp_reset;
    logic [31:0] d;
    int          acks, ticks, lit_data;
    reset_dut;
    load_img(16'h0050, 4'b0110, 4'b0, 1'b1);
    cap_frame(d);
    vec++; if (d !== 32'h0001B7FC) begin err++; $display("FAIL dp got %h want 0001B7FC", d); end
    digit_val = 16'h1111;
    lzb_en = 1'b0;
    load = 1'b1;
    skip(1);
    load = 1'b0;
    skip(5);
    rst = 1'b1;
    skip(1);
    vec++; if (fnd_com !== 4'hF) begin err++; $display("FAIL rst_mid_com got %b want 1111", fnd_com); end
    vec++; if (fnd_data !== 8'h00) begin err++; $display("FAIL rst_mid_data got %h want 00", fnd_data); end
    vec++; if (load_ack !== 1'b0) begin err++; $display("FAIL rst_mid_ack got %b want 0", load_ack); end
    vec++; if (frame_tick !== 1'b0) begin err++; $display("FAIL rst_mid_tick got %b want 0", frame_tick); end
    rst = 1'b0;
    acks = 0;
    ticks = 0;
    lit_data = 0;
    for (int k = 1; k <= 40; k++) begin
      skip(1);
      if (k == 1) begin
        vec++; if (fnd_com !== 4'b0111) begin err++; $display("FAIL rst_first_lit got %b want 0111", fnd_com); end
      end
      acks += int'(load_ack);
      ticks += int'(frame_tick);
      lit_data += int'(fnd_data != 8'h00);
    end
    vec++; if (acks != 0) begin err++; $display("FAIL rst_pending acks got %0d want 0", acks); end
    vec++; if (ticks != 2) begin err++; $display("FAIL rst_ticks got %0d want 2", ticks); end
    vec++; if (lit_data != 0) begin err++; $display("FAIL rst_image nonblank got %0d want 0", lit_data); end
  endtask

  initial begin
    test_reset;
    test_lzb;
    test_buffering;
    test_blink;
    test_brightness;
    test_dp_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
